// File: rtl/sha256_msg_schedule_if.sv
// Handshake/bus bundle between a block producer/schedule consumer and the
// SHA-256 message-schedule expander.
//   block_valid/block_data/block_ready : 512-bit message block in
//   w/w_valid/w_ready                  : 2048-bit expanded schedule out
//   busy                               : expansion in progress
// master = producer/consumer side, slave = expander side.
interface sha256_msg_schedule_if;
  logic           block_valid;
  logic [511:0]   block_data;
  logic           block_ready;
  logic [2047:0]  w;
  logic           w_valid;
  logic           w_ready;
  logic           busy;

  modport master (
    output block_valid, block_data, w_ready,
    input  block_ready, w, w_valid, busy
  );

  modport slave (
    input  block_valid, block_data, w_ready,
    output block_ready, w, w_valid, busy
  );
endinterface

// File: rtl/sha256_msg_schedule.sv
// SHA-256 message-schedule expander.
// Accepts one 512-bit block (M[0] in bits 511:480), expands it in place into
// W[0..63] and presents the schedule on bus.w (W[i] = w[i*32 +: 32]) until
// the consumer takes it.
// Ports:
//   clk     : rising-edge clock
//   reset_n : asynchronous active-low reset
//   bus     : sha256_msg_schedule_if.slave (block in, schedule out, busy)
// Build option:
//   MSG_SCHED_DUAL_EN : when defined, two schedule words are produced per
//                       edge (24 expand edges instead of 48).
module sha256_msg_schedule (
  input  logic                  clk,
  input  logic                  reset_n,
  sha256_msg_schedule_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_EXPAND = 2'd1,
    S_DONE   = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [5:0]         idx_q, idx_d;
  logic [63:0][31:0]  w_q, w_d;

  function automatic logic [31:0] sig0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sig1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

  function automatic logic [31:0] next_word(input logic [31:0] w2, w7, w15, w16);
    return sig1(w2) + w7 + sig0(w15) + w16;
  endfunction

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    w_d     = w_q;
    case (state_q)
      S_IDLE: begin
        if (bus.block_valid) begin
          for (int t = 0; t < 16; t++) w_d[t] = bus.block_data[(15-t)*32 +: 32];
          for (int t = 16; t < 64; t++) w_d[t] = '0;
          idx_d   = 6'd16;
          state_d = S_EXPAND;
        end
      end
      S_EXPAND: begin
`ifdef MSG_SCHED_DUAL_EN
        // Second word takes W[idx-1] as its sigma1 operand, so both words
        // depend only on already-registered state.
        w_d[idx_q]        = next_word(w_q[idx_q - 6'd2], w_q[idx_q - 6'd7],
                                      w_q[idx_q - 6'd15], w_q[idx_q - 6'd16]);
        w_d[idx_q + 6'd1] = next_word(w_q[idx_q - 6'd1], w_q[idx_q - 6'd6],
                                      w_q[idx_q - 6'd14], w_q[idx_q - 6'd15]);
        if (idx_q == 6'd62) state_d = S_DONE;
        else                idx_d   = idx_q + 6'd2;
`else
        w_d[idx_q] = next_word(w_q[idx_q - 6'd2], w_q[idx_q - 6'd7],
                               w_q[idx_q - 6'd15], w_q[idx_q - 6'd16]);
        // idx parks at 63 instead of wrapping to 0
        if (idx_q == 6'd63) state_d = S_DONE;
        else                idx_d   = idx_q + 6'd1;
`endif
      end
      S_DONE: begin
        if (bus.w_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      idx_q   <= 6'd16;
      w_q     <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      w_q     <= w_d;
    end
  end

  // All outputs come straight from registers.
  assign bus.block_ready = (state_q == S_IDLE);
  assign bus.w_valid     = (state_q == S_DONE);
  assign bus.busy        = (state_q == S_EXPAND);
  assign bus.w           = w_q;

endmodule

// File: tb/tb_sha256_msg_schedule.sv
module tb_sha256_msg_schedule;

`ifdef MSG_SCHED_DUAL_EN
  localparam int LAT = 24;
  localparam int PERIOD = 26;
  localparam int MID_EDGES = 7;
`else
  localparam int LAT = 48;
  localparam int PERIOD = 50;
  localparam int MID_EDGES = 14;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   cyc = 0;
  int   ntot = 0;
  int   npass = 0;

  sha256_msg_schedule_if bus_if ();

  sha256_msg_schedule dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_if)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- reference model ----------------
  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [2047:0] model(input logic [511:0] m);
    logic [31:0]   ww [64];
    logic [2047:0] r;
    logic [31:0]   s0, s1;
    for (int t = 0; t < 16; t++) ww[t] = m[511 - 32*t -: 32];
    for (int t = 16; t < 64; t++) begin
      s0 = rotr(ww[t-15], 7) ^ rotr(ww[t-15], 18) ^ (ww[t-15] >> 3);
      s1 = rotr(ww[t-2], 17) ^ rotr(ww[t-2], 19) ^ (ww[t-2] >> 10);
      ww[t] = s1 + ww[t-7] + s0 + ww[t-16];
    end
    for (int t = 0; t < 64; t++) r[t*32 +: 32] = ww[t];
    return r;
  endfunction

  function automatic logic [511:0] rand_block();
    logic [511:0] b;
    for (int t = 0; t < 16; t++) b[t*32 +: 32] = $urandom;
    return b;
  endfunction

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: got %h, expected %h", tag, obs, exp);
  endtask

  task automatic chkw(input string tag, input logic [2047:0] obs, input logic [2047:0] exp);
    int bad;
    bad = 0;
    for (int i = 63; i >= 0; i--) if (obs[i*32 +: 32] !== exp[i*32 +: 32]) bad = i;
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: W[%0d] got %h, expected %h", tag, bad, obs[bad*32 +: 32], exp[bad*32 +: 32]);
  endtask

  // Presents a block until it is accepted; returns with the accept edge just past.
  task automatic send(input logic [511:0] blk, output int acc);
    int n;
    n = 0;
    bus_if.block_valid = 1'b1;
    bus_if.block_data  = blk;
    while (!bus_if.block_ready && n < 300) begin tick(); n++; end
    chk("accept_ready", {31'd0, bus_if.block_ready}, 32'd1);
    tick();
    acc = cyc;
    bus_if.block_valid = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!bus_if.w_valid && n < 300) begin tick(); n++; end
  endtask

  // ---------------- stimulus ----------------
  logic [511:0]  abc, blk_a, blk_b, blk_c;
  logic [2047:0] exp_w;
  int            acc1, acc2, n;
  bit            seen_a;

  initial begin
    bus_if.block_valid = 1'b0;
    bus_if.block_data  = '0;
    bus_if.w_ready     = 1'b0;
    #1;
    chk("rst_block_ready", {31'd0, bus_if.block_ready}, 32'd1);
    chk("rst_w_valid",     {31'd0, bus_if.w_valid},     32'd0);
    chk("rst_busy",        {31'd0, bus_if.busy},        32'd0);
    chkw("rst_w", bus_if.w, '0);
    repeat (2) tick();
    reset_n = 1'b1;
    tick();

    // "abc" block, latency, known words
    abc = {32'h61626380, 448'h0, 32'h00000018};
    send(abc, acc1);
    wait_valid(n);
    chk("abc_latency", n, LAT);
    chk("abc_W0",  bus_if.w[0*32 +: 32],  32'h61626380);
    chk("abc_W16", bus_if.w[16*32 +: 32], 32'h61626380);
    chk("abc_W17", bus_if.w[17*32 +: 32], 32'h000F0000);
    chk("abc_W63", bus_if.w[63*32 +: 32], 32'h12B1EDEB);
    chkw("abc_full", bus_if.w, model(abc));

    // back-pressure in DONE; a new block must be ignored
    blk_a = rand_block();
    bus_if.block_valid = 1'b1;
    bus_if.block_data  = blk_a;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_w_valid",     {31'd0, bus_if.w_valid},     32'd1);
      chk("bp_block_ready", {31'd0, bus_if.block_ready}, 32'd0);
      chkw("bp_w_stable", bus_if.w, model(abc));
    end
    bus_if.block_valid = 1'b0;
    bus_if.w_ready = 1'b1;
    tick();
    chk("bp_release_valid", {31'd0, bus_if.w_valid},     32'd0);
    chk("bp_release_ready", {31'd0, bus_if.block_ready}, 32'd1);
    chkw("bp_w_held", bus_if.w, model(abc));

    // all-zero block, busy duration
    send('0, acc1);
    n = 0;
    while (bus_if.busy && n < 300) begin n++; tick(); end
    chk("zero_busy_cycles", n, LAT);
    chk("zero_w_valid", {31'd0, bus_if.w_valid}, 32'd1);
    chkw("zero_full", bus_if.w, '0);

    // back-to-back with w_ready high and block_valid held
    tick();
    blk_a = rand_block();
    blk_b = rand_block();
    bus_if.block_valid = 1'b1;
    bus_if.block_data  = blk_a;
    n = 0;
    while (!bus_if.block_ready && n < 300) begin tick(); n++; end
    tick();
    acc1 = cyc;
    bus_if.block_data = blk_b;
    seen_a = 1'b0;
    acc2 = 0;
    n = 0;
    while (n < 300) begin
      tick();
      n++;
      if (bus_if.w_valid && !seen_a) begin
        seen_a = 1'b1;
        chkw("b2b_first", bus_if.w, model(blk_a));
      end
      if (seen_a && bus_if.busy) begin
        acc2 = cyc;
        break;
      end
    end
    bus_if.block_valid = 1'b0;
    chk("b2b_period", acc2 - acc1, PERIOD);
    wait_valid(n);
    chkw("b2b_second", bus_if.w, model(blk_b));

    // reset in the middle of expansion (idx = 30)
    tick();
    send(rand_block(), acc1);
    repeat (MID_EDGES) tick();
    reset_n = 1'b0;
    #1;
    chk("midrst_busy",        {31'd0, bus_if.busy},        32'd0);
    chk("midrst_block_ready", {31'd0, bus_if.block_ready}, 32'd1);
    chk("midrst_w_valid",     {31'd0, bus_if.w_valid},     32'd0);
    chkw("midrst_w", bus_if.w, '0);
    reset_n = 1'b1;
    blk_c = rand_block();
    send(blk_c, acc1);
    wait_valid(n);
    chk("midrst_latency", n, LAT);
    chkw("midrst_after", bus_if.w, model(blk_c));

    // random blocks
    for (int k = 0; k < 1000; k++) begin
      blk_c = rand_block();
      exp_w = model(blk_c);
      send(blk_c, acc1);
      wait_valid(n);
      chkw("rand_block", bus_if.w, exp_w);
    end

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
